// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART byte-to-frame decoder.
package uart_frame_pkg;

  // Frame parser states, in the order a well-formed frame walks through them.
  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ID,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;

  // Default frame start marker.
  localparam logic [7:0] DEFAULT_SYNC = 8'hAA;

  // States in which a frame is partially received and the inter-byte
  // timeout is armed.
  function automatic logic is_parsing(input state_t s);
    return (s == ST_ID) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 storage, one write port, one registered read port.
module uart_frame_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Wr_En,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [7:0]        i_Wr_Data,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // Write port.
  // NOTE: the storage array has no reset; only the read register is cleared,
  // which keeps the array mappable onto plain RAM/register-file cells.
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Read port address decode.
  always_comb begin
    rd_data_d = mem_q[i_Rd_Addr];
  end

  // Registered read data, giving one cycle of read latency.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/uart_frame_decoder.sv
// Hunts for SYNC in the UART byte stream, parses ID/LEN/payload/CHK, and
// holds a checksum-verified frame for the consumer until it is acknowledged.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
  parameter int         TIMEOUT_CLKS = 48_000,
  localparam int        LEN_W        = $clog2(MAX_LEN + 1),
  localparam int        ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Frame_Valid,
  input  logic              i_Frame_Ack,
  output logic [7:0]        o_Frame_Id,
  output logic [LEN_W-1:0]  o_Frame_Len,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Err_Chk,
  output logic              o_Err_Len,
  output logic              o_Err_Timeout,
  output logic              o_Overrun
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]       LEN_MAX9 = 9'(MAX_LEN);

  state_t             state_q,   state_d;
  logic [7:0]         id_q,      id_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic [7:0]         sum_q,     sum_d;
  logic [LEN_W-1:0]   widx_q,    widx_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               err_chk_q, err_chk_d;
  logic               err_len_q, err_len_d;
  logic               err_to_q,  err_to_d;
  logic               ovr_q,     ovr_d;
  logic               wr_en;

  // Next-state, datapath updates and error pulse generation.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    sum_d     = sum_q;
    widx_d    = widx_q;
    cnt_d     = '0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    ovr_d     = 1'b0;
    wr_en     = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        if (i_Rx_DV) begin
          id_d    = i_Rx_Byte;
          sum_d   = i_Rx_Byte;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (i_Rx_DV) begin
          if ({1'b0, i_Rx_Byte} > LEN_MAX9) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d   = LEN_W'(i_Rx_Byte);
            sum_d   = sum_q + i_Rx_Byte;
            widx_d  = '0;
            state_d = (i_Rx_Byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          wr_en  = 1'b1;
          sum_d  = sum_q + i_Rx_Byte;
          widx_d = widx_q + LEN_W'(1);
          if (widx_q == (len_q - LEN_W'(1))) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == sum_q) begin
            state_d = ST_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end

      ST_HOLD: begin
        // The held frame is frozen: bytes arriving now are dropped.
        if (i_Rx_DV) begin
          ovr_d = 1'b1;
        end
        if (i_Frame_Ack) begin
          state_d = ST_HUNT;
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Inter-byte timeout; a byte strobe in this cycle always wins.
    if (is_parsing(state_q) && !i_Rx_DV) begin
      if (cnt_q == CNT_LAST) begin
        err_to_d = 1'b1;
        state_d  = ST_HUNT;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before this edge.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q   <= ST_HUNT;
      id_q      <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      widx_q    <= '0;
      cnt_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      widx_q    <= widx_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      ovr_q     <= ovr_d;
    end
  end

  uart_frame_buf #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (wr_en),
    .i_Wr_Addr (widx_q[ADDR_W-1:0]),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (i_Rd_Addr),
    .o_Rd_Data (o_Rd_Data)
  );

  assign o_Frame_Valid = (state_q == ST_HOLD);
  assign o_Frame_Id    = id_q;
  assign o_Frame_Len   = len_q;
  assign o_Err_Chk     = err_chk_q;
  assign o_Err_Len     = err_len_q;
  assign o_Err_Timeout = err_to_q;
  assign o_Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed scenarios plus
// randomized frames checked against expectations computed from frame contents.
`timescale 1ns/1ps
module tb_uart_frame_decoder;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 64;
  localparam int LEN_W   = 5;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              ack = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              frame_valid;
  logic [7:0]        frame_id;
  logic [LEN_W-1:0]  frame_len;
  logic [7:0]        rd_data;
  logic              err_chk, err_len, err_to, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

  always #5 clk = ~clk;

  uart_frame_decoder #(
    .MAX_LEN      (MAX_LEN),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_Frame_Valid (frame_valid),
    .i_Frame_Ack   (ack),
    .o_Frame_Id    (frame_id),
    .o_Frame_Len   (frame_len),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Data     (rd_data),
    .o_Err_Chk     (err_chk),
    .o_Err_Len     (err_len),
    .o_Err_Timeout (err_to),
    .o_Overrun     (overrun)
  );

  // Pulse monitor: counts high cycles of each pulse output, sampled mid-cycle.
  always @(posedge clk) begin
    #2;
    if (err_chk) n_chk++;
    if (err_len) n_len++;
    if (err_to)  n_to++;
    if (overrun) n_ovr++;
  end

  // Drive bytes on consecutive cycles; returns one cycle after the last strobe.
  task automatic drive_bytes(input logic [7:0] bq[$]);
    foreach (bq[i]) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = bq[i];
    end
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if ({frame_valid, err_chk, err_len, err_to, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {frame_valid, err_chk, err_len, err_to, overrun});
    end
    n_checks++;
    if (frame_id !== 8'h00 || frame_len !== '0) begin
      n_fail++;
      $display("FAIL reset_id_len: got id=%h len=%0d expected 0/0", frame_id, frame_len);
    end
    n_checks++;
    if (rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame();
    int e0 = n_chk + n_len + n_to + n_ovr;
    drive_bytes('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20});
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_early: got %b expected 0", frame_valid);
    end
    drive_bytes('{8'h33});
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h01 || frame_len !== 5'd2) begin
      n_fail++;
      $display("FAIL valid_frame: got v=%b id=%h len=%0d expected 1/01/2", frame_valid, frame_id, frame_len);
    end
    @(negedge clk); rd_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if (rd_data !== 8'h10) begin
      n_fail++;
      $display("FAIL valid_rd0: got %h expected 10", rd_data);
    end
    rd_addr = 4'd1;
    @(negedge clk);
    n_checks++;
    if (rd_data !== 8'h20) begin
      n_fail++;
      $display("FAIL valid_rd1: got %h expected 20", rd_data);
    end
    do_ack();
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_ack: got %b expected 0", frame_valid);
    end
    n_checks++;
    if (n_chk + n_len + n_to + n_ovr != e0) begin
      n_fail++;
      $display("FAIL valid_no_err: got %0d pulses expected 0", n_chk + n_len + n_to + n_ovr - e0);
    end
  endtask

  task automatic test_bad_checksum();
    int c0 = n_chk;
    drive_bytes('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34});
    n_checks++;
    if (err_chk !== 1'b1 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL badchk_pulse: got err=%b v=%b expected 1/0", err_chk, frame_valid);
    end
    idle(1);
    n_checks++;
    if (n_chk - c0 != 1) begin
      n_fail++;
      $display("FAIL badchk_width: got %0d cycles expected 1", n_chk - c0);
    end
    drive_bytes('{8'hAA, 8'h02, 8'h01, 8'h55, 8'h58});
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h02 || frame_len !== 5'd1) begin
      n_fail++;
      $display("FAIL badchk_recover: got v=%b id=%h len=%0d expected 1/02/1", frame_valid, frame_id, frame_len);
    end
    @(negedge clk); rd_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if (rd_data !== 8'h55) begin
      n_fail++;
      $display("FAIL badchk_rd: got %h expected 55", rd_data);
    end
    do_ack();
  endtask

  task automatic test_length();
    int l0 = n_len;
    drive_bytes('{8'hAA, 8'h05, 8'h11});
    n_checks++;
    if (err_len !== 1'b1) begin
      n_fail++;
      $display("FAIL len_pulse: got %b expected 1", err_len);
    end
    idle(1);
    n_checks++;
    if (n_len - l0 != 1 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len_width: got %0d cycles v=%b expected 1/0", n_len - l0, frame_valid);
    end
    drive_bytes('{8'hAA, 8'h07, 8'h00, 8'h07});
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h07 || frame_len !== 5'd0) begin
      n_fail++;
      $display("FAIL len_zero: got v=%b id=%h len=%0d expected 1/07/0", frame_valid, frame_id, frame_len);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int t0 = n_to;
    int e0;
    int seen = -1;
    logic [7:0] g[$];
    // Gaps one clock short of the timeout must not abort the frame.
    drive_bytes('{8'hAA}); idle(TIMEOUT - 2);
    drive_bytes('{8'h01}); idle(TIMEOUT - 2);
    drive_bytes('{8'h00}); idle(TIMEOUT - 2);
    drive_bytes('{8'h01});
    n_checks++;
    if (frame_valid !== 1'b1 || n_to != t0) begin
      n_fail++;
      $display("FAIL timeout_slow_frame: got v=%b pulses=%0d expected 1/0", frame_valid, n_to - t0);
    end
    do_ack();
    // Silence after the ID byte.
    drive_bytes('{8'hAA, 8'h01});
    for (int k = 1; k <= 3 * TIMEOUT; k++) begin
      @(negedge clk);
      if (err_to) begin
        seen = k;
        break;
      end
    end
    n_checks++;
    if (seen != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d idle clocks expected %0d", seen, TIMEOUT);
    end
    idle(1);
    n_checks++;
    if (n_to - t0 != 1) begin
      n_fail++;
      $display("FAIL timeout_width: got %0d cycles expected 1", n_to - t0);
    end
    e0 = n_chk + n_len + n_to + n_ovr;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      g.push_back((b == 8'hAA) ? 8'h3C : b);
    end
    drive_bytes(g);
    idle(3 * TIMEOUT);
    n_checks++;
    if (n_chk + n_len + n_to + n_ovr != e0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_garbage: got %0d pulses v=%b expected 0/0", n_chk + n_len + n_to + n_ovr - e0, frame_valid);
    end
  endtask

  task automatic test_overrun();
    int o0;
    int l0 = n_len;
    logic [7:0] exp_pl[3] = '{8'h01, 8'h02, 8'h03};
    drive_bytes('{8'hAA, 8'h09, 8'h03, 8'h01, 8'h02, 8'h03, 8'h12});
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_hold: got %b expected 1", frame_valid);
    end
    o0 = n_ovr;
    drive_bytes('{8'hAA, 8'h11, 8'h22});
    n_checks++;
    if (n_ovr - o0 != 3) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d expected 3", n_ovr - o0);
    end
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h09 || frame_len !== 5'd3) begin
      n_fail++;
      $display("FAIL ovr_frozen: got v=%b id=%h len=%0d expected 1/09/3", frame_valid, frame_id, frame_len);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); rd_addr = ADDR_W'(i);
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_pl[i]) begin
        n_fail++;
        $display("FAIL ovr_payload[%0d]: got %h expected %h", i, rd_data, exp_pl[i]);
      end
    end
    // Ack coincident with a SYNC byte: byte dropped, overrun flagged.
    @(negedge clk);
    ack = 1'b1; rx_dv = 1'b1; rx_byte = 8'hAA;
    @(negedge clk);
    ack = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    n_checks++;
    if (frame_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_ack_same: got v=%b ovr=%b expected 0/1", frame_valid, overrun);
    end
    drive_bytes('{8'h05, 8'hAA, 8'h04, 8'h00, 8'h04});
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h04 || frame_len !== 5'd0 || n_len != l0) begin
      n_fail++;
      $display("FAIL ovr_rehunt: got v=%b id=%h len=%0d lenerr=%0d expected 1/04/0/0", frame_valid, frame_id, frame_len, n_len - l0);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    int e0 = n_chk + n_len + n_to + n_ovr;
    logic [7:0] exp_pl[2] = '{8'h0A, 8'h0B};
    drive_bytes('{8'hAA, 8'h03, 8'h04, 8'h01, 8'h02});
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({frame_valid, err_chk, err_len, err_to, overrun} !== 5'b0 || frame_id !== 8'h00 ||
        frame_len !== '0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got v=%b id=%h len=%0d rd=%h flags=%b expected all 0",
               frame_valid, frame_id, frame_len, rd_data, {err_chk, err_len, err_to, overrun});
    end
    rst_n = 1'b1;
    idle(2 * TIMEOUT);
    n_checks++;
    if (n_chk + n_len + n_to + n_ovr != e0) begin
      n_fail++;
      $display("FAIL rst_mid_no_err: got %0d pulses expected 0", n_chk + n_len + n_to + n_ovr - e0);
    end
    drive_bytes('{8'hAA, 8'h03, 8'h02, 8'h0A, 8'h0B, 8'h1A});
    n_checks++;
    if (frame_valid !== 1'b1 || frame_id !== 8'h03 || frame_len !== 5'd2) begin
      n_fail++;
      $display("FAIL rst_mid_frame: got v=%b id=%h len=%0d expected 1/03/2", frame_valid, frame_id, frame_len);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rd_addr = ADDR_W'(i);
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_pl[i]) begin
        n_fail++;
        $display("FAIL rst_mid_payload[%0d]: got %h expected %h", i, rd_data, exp_pl[i]);
      end
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 30; it++) begin
      logic [7:0] q[$];
      logic [7:0] pl[$];
      int kind = $urandom_range(0, 9);
      int id   = $urandom_range(0, 255);
      int len;
      int sum;
      int c0 = n_chk, l0 = n_len, t0 = n_to, o0 = n_ovr;
      if (kind == 9) len = $urandom_range(MAX_LEN + 1, 255);
      else if (it % 5 == 0) len = MAX_LEN;
      else len = $urandom_range(0, MAX_LEN);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        logic [7:0] b = 8'($urandom_range(0, 255));
        q.push_back((b == 8'hAA) ? 8'h00 : b);
      end
      q.push_back(8'hAA);
      q.push_back(8'(id));
      q.push_back(8'(len));
      if (kind != 9) begin
        sum = id + len;
        for (int i = 0; i < len; i++) begin
          logic [7:0] b = (i == 0 && it % 3 == 0) ? 8'hAA : 8'($urandom_range(0, 255));
          pl.push_back(b);
          q.push_back(b);
          sum += int'(b);
        end
        if (kind >= 7) sum += $urandom_range(1, 255);
        q.push_back(8'(sum % 256));
      end
      drive_bytes(q);
      if (kind <= 6) begin
        n_checks++;
        if (frame_valid !== 1'b1 || frame_id !== 8'(id) || frame_len !== LEN_W'(len) ||
            n_chk != c0 || n_len != l0 || n_to != t0 || n_ovr != o0) begin
          n_fail++;
          $display("FAIL b2b_good[%0d]: got v=%b id=%h len=%0d expected 1/%h/%0d", it, frame_valid, frame_id, frame_len, id, len);
        end
        for (int i = 0; i < len; i++) begin
          @(negedge clk); rd_addr = ADDR_W'(i);
          @(negedge clk);
          n_checks++;
          if (rd_data !== pl[i]) begin
            n_fail++;
            $display("FAIL b2b_payload[%0d][%0d]: got %h expected %h", it, i, rd_data, pl[i]);
          end
        end
        do_ack();
      end else if (kind <= 8) begin
        n_checks++;
        if (frame_valid !== 1'b0 || n_chk - c0 != 1) begin
          n_fail++;
          $display("FAIL b2b_badchk[%0d]: got v=%b pulses=%0d expected 0/1", it, frame_valid, n_chk - c0);
        end
      end else begin
        n_checks++;
        if (frame_valid !== 1'b0 || n_len - l0 != 1) begin
          n_fail++;
          $display("FAIL b2b_toolong[%0d]: got v=%b pulses=%0d expected 0/1", it, frame_valid, n_len - l0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-to-frame stage directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes and hunts for a sync byte. It parses ID, length, payload and checksum, buffers the payload, and presents a complete, checksum-verified frame to the register/motor-command logic through a valid/ack handshake. Malformed, stalled or overrunning traffic is discarded and reported with one-cycle error pulses.

## Interface
- `MAX_LEN`, 16: maximum payload bytes; power of two, 1..256.
- `SYNC_BYTE`, 8'hAA: frame start marker.
- `TIMEOUT_CLKS`, 48_000: inter-byte timeout in clocks (1 ms at 48 MHz).
- `i_Clock` in 1: system clock, all logic on rising edge.
- `i_Reset_n` in 1: synchronous, active-low reset.
- `i_Rx_DV` in 1: byte strobe from the UART receiver, one cycle per byte.
- `i_Rx_Byte` in 8: received byte, valid when `i_Rx_DV`=1.
- `o_Frame_Valid` out 1: complete verified frame held for the consumer.
- `i_Frame_Ack` in 1: consumer releases the frame.
- `o_Frame_Id` out 8: ID of the held frame.
- `o_Frame_Len` out $clog2(MAX_LEN+1): payload length of the held frame.
- `i_Rd_Addr` in $clog2(MAX_LEN): payload read index.
- `o_Rd_Data` out 8: payload byte at `i_Rd_Addr`, registered.
- `o_Err_Chk` out 1: checksum mismatch pulse.
- `o_Err_Len` out 1: length > `MAX_LEN` pulse.
- `o_Err_Timeout` out 1: inter-byte timeout pulse.
- `o_Overrun` out 1: byte dropped while a frame is held.

## Operation
- Frame format: SYNC, ID, LEN, LEN payload bytes, CHK.
- CHK = (ID + LEN + Σpayload) mod 256.
- States:
  - HUNT: bytes ≠ SYNC are ignored. SYNC → ID.
  - ID: on a byte, latch ID and set sum = byte → LEN.
  - LEN: on a byte, if it exceeds `MAX_LEN`, pulse `o_Err_Len` → HUNT. Otherwise latch LEN and add it to sum. LEN=0 → CHK; otherwise → PAYLOAD.
  - PAYLOAD: write each byte to the buffer at the write index, add it to sum, and increment the index. After LEN bytes → CHK.
  - CHK: on a byte, if it equals sum → HOLD with `o_Frame_Valid`=1. Otherwise pulse `o_Err_Chk` → HUNT.
  - HOLD: `o_Frame_Id`, `o_Frame_Len` and the buffer are frozen. Every `i_Rx_DV` pulses `o_Overrun` and the byte is dropped. `i_Frame_Ack` → HUNT with `o_Frame_Valid`=0.
- The sum is 8-bit and wraps. The write index resets to 0 on entering PAYLOAD.
- A SYNC byte inside ID/LEN/PAYLOAD/CHK is treated as data; there is no resync.
- Timeout: in ID, LEN, PAYLOAD and CHK, the counter clears on every `i_Rx_DV` and otherwise increments. When it reaches `TIMEOUT_CLKS-1`, pulse `o_Err_Timeout` → HUNT. The counter is held at 0 in HUNT and HOLD.
- `i_Frame_Ack` outside HOLD is ignored.
- `i_Rd_Addr` ≥ `o_Frame_Len` returns stale buffer contents. Reads outside HOLD are undefined.

## Timing
- Reset (`i_Reset_n`=0 at a clock edge):
  - state HUNT.
  - all outputs 0, including `o_Frame_Id`, `o_Frame_Len` and `o_Rd_Data`.
  - counters and sum cleared; buffer contents not cleared.
- Reset mid-frame or in HOLD discards the frame with no error pulse.
- `o_Frame_Valid` rises the cycle after the `i_Rx_DV` carrying a correct CHK.
- All error pulses are exactly one cycle wide and are asserted the cycle after the causing event.
- `o_Rd_Data` has 1-cycle read latency from `i_Rd_Addr`.
- `i_Frame_Ack` and `i_Rx_DV` in the same HOLD cycle: the ack is taken, the byte is dropped and `o_Overrun` pulses. Parsing restarts with the next byte.
- `o_Frame_Valid` falls the cycle after `i_Frame_Ack`.
- Back-to-back bytes (`i_Rx_DV` in consecutive cycles) must be accepted in every state.

## Structure
- Package `uart_frame_pkg`: state enum (HUNT, ID, LEN, PAYLOAD, CHK, HOLD) and the default SYNC constant.
- Sub-module `uart_frame_buf`:
  - `MAX_LEN`×8 storage, one write port, one read port.
  - synchronous registered read, no reset on storage.
- Top level: FSM, sum accumulator, write index, timeout counter, output registers.

## Test plan
- Valid frame: AA 01 02 10 20 33.
  - `o_Frame_Valid`=1 one cycle after the 0x33 strobe; Id=0x01, Len=2.
  - reads at addr 0/1 give 0x10/0x20 one cycle later.
  - ack → `o_Frame_Valid`=0 next cycle.
- Bad checksum: AA 01 02 10 20 34 → one `o_Err_Chk` pulse, no valid. A following valid frame is then accepted.
- Length: AA 05 11 (LEN 17 > 16) → `o_Err_Len` pulse, state HUNT. AA 07 00 07 → valid frame with Len=0.
- Timeout: AA 01, then silence for `TIMEOUT_CLKS` clocks → one `o_Err_Timeout` pulse. Garbage bytes ≠ 0xAA afterwards produce no pulses.
- Overrun: hold a frame without ack and send 3 bytes → 3 `o_Overrun` pulses, held Id/payload unchanged. Then ack coincident with a byte strobe → overrun pulse and clean re-hunt.
- Reset: assert `i_Reset_n`=0 mid-payload → all outputs 0, no error pulse. A subsequent complete frame decodes correctly.
